generador_sincronia_vga: RTL and testbench

- Parametrised VGA timing generator for the video path; derives horizontal and vertical sync from one system clock.
- Contains a pixel-clock prescaler, horizontal and vertical counters, registered sync/blanking decode, and frame/line start strobes.
- Replaces separate per-axis sync decoders fed by external counters.
- Downstream pixel generators consume pixel_x, pixel_y, video_on and pixel_tick.

---
 rtl/generador_sincronia_vga_if.sv | 33 +++
 rtl/generador_sincronia_vga.sv | 99 +++++++++
 tb/tb_generador_sincronia_vga.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/generador_sincronia_vga_if.sv
// VGA timing bundle between the sync generator and downstream pixel logic.
//   enable       run control driven by the consumer side
//   pixel_tick   one-clk pulse per pixel period
//   hsync/vsync  sync levels at their configured polarity
//   video_on     visible-area flag aligned with pixel_x/pixel_y
//   pixel_x/y    current horizontal/vertical counts
//   line_start   one-clk pulse when pixel_x becomes 0
//   frame_start  one-clk pulse when (pixel_x, pixel_y) becomes (0,0)
interface generador_sincronia_vga_if #(
  parameter int CW = 10
);
  logic          enable;
  logic          pixel_tick;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  enable,
    output pixel_tick, hsync, vsync, video_on,
    output pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    output enable,
    input  pixel_tick, hsync, vsync, video_on,
    input  pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/generador_sincronia_vga.sv
// Parametrised VGA timing generator running from the system clock.
// A prescaler produces pixel_tick every CLK_DIV enabled clocks; the pixel
// counters advance on each tick and the sync/blanking/strobe outputs are
// registered from the next counter values so they line up with pixel_x/y.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   vga      timing bundle (master side): enable in, timing outputs out
module generador_sincronia_vga #(
  parameter int CW        = 10,
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  generador_sincronia_vga_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] X_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_MAX   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_VIS   = CW'(H_VISIBLE);
  localparam logic [CW-1:0] Y_VIS   = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END  = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic [CW-1:0] x_q, y_q;
  logic [CW-1:0] nx, ny;
  logic          tick;
  logic          hs_q, vs_q, vid_q, ls_q, fs_q;
  logic          hs_act, vs_act, vid_nxt;

  assign tick = vga.enable & (presc == P_LAST);

  always_comb begin
    nx = x_q + CW'(1);
    ny = y_q;
    if (x_q == X_MAX) begin
      nx = '0;
      ny = (y_q == Y_MAX) ? '0 : y_q + CW'(1);
    end
    hs_act  = (nx >= HS_BEG) && (nx <= HS_END);
    vs_act  = (ny >= VS_BEG) && (ny <= VS_END);
    vid_nxt = (nx < X_VIS) && (ny < Y_VIS);
  end

  // Strobes are held (not cleared) while disabled and masked at the output,
  // so a strobe pending when enable drops is delivered on resume instead of lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= ~HSYNC_POL;
      vs_q  <= ~VSYNC_POL;
      vid_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else if (vga.enable) begin
      presc <= tick ? '0 : presc + PW'(1);
      ls_q  <= tick && (nx == '0);
      fs_q  <= tick && (nx == '0) && (ny == '0);
      if (tick) begin
        x_q   <= nx;
        y_q   <= ny;
        hs_q  <= hs_act ? HSYNC_POL : ~HSYNC_POL;
        vs_q  <= vs_act ? VSYNC_POL : ~VSYNC_POL;
        vid_q <= vid_nxt;
      end
    end
  end

  // With CLK_DIV=1 the prescaler sits at its last value during reset, so the
  // combinational tick is gated to keep it low while reset_n is asserted.
  assign vga.pixel_tick  = tick & reset_n;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.video_on    = vid_q;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.line_start  = ls_q & vga.enable;
  assign vga.frame_start = fs_q & vga.enable;

endmodule

// File: tb/tb_generador_sincronia_vga.sv
module tb_generador_sincronia_vga;

  typedef struct {
    int k, hv, hf, hs, hb, vv, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    longint x, y;
    bit tick, hs, vs, vid, ls, fs;
  } exp_t;

  function automatic cfg_t get_cfg(int i);
    cfg_t c;
    case (i)
      0:       c = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
      1:       c = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
      default: c = '{3, 5, 2, 3, 2, 3, 1, 2, 2, 1'b0, 1'b1};
    endcase
    return c;
  endfunction

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] en = 3'b000;
  bit rand_on = 1'b0;
  bit rand0 = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  generador_sincronia_vga_if #(.CW(10)) i0 ();
  generador_sincronia_vga_if #(.CW(4))  i1 ();
  generador_sincronia_vga_if #(.CW(5))  i2 ();

  assign i0.enable = en[0];
  assign i1.enable = en[1];
  assign i2.enable = en[2];

  generador_sincronia_vga #(
    .CW(10), .CLK_DIV(2),
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut0 (.clk(clk), .reset_n(reset_n), .vga(i0));

  generador_sincronia_vga #(
    .CW(4), .CLK_DIV(1),
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut1 (.clk(clk), .reset_n(reset_n), .vga(i1));

  generador_sincronia_vga #(
    .CW(5), .CLK_DIV(3),
    .H_VISIBLE(5), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) dut2 (.clk(clk), .reset_n(reset_n), .vga(i2));

  logic [9:0] ax [3];
  logic [9:0] ay [3];
  logic [2:0] atick, ahs, avs, avid, als, afs;

  assign ax[0] = i0.pixel_x;
  assign ax[1] = {6'd0, i1.pixel_x};
  assign ax[2] = {5'd0, i2.pixel_x};
  assign ay[0] = i0.pixel_y;
  assign ay[1] = {6'd0, i1.pixel_y};
  assign ay[2] = {5'd0, i2.pixel_y};
  assign atick = {i2.pixel_tick, i1.pixel_tick, i0.pixel_tick};
  assign ahs   = {i2.hsync, i1.hsync, i0.hsync};
  assign avs   = {i2.vsync, i1.vsync, i0.vsync};
  assign avid  = {i2.video_on, i1.video_on, i0.video_on};
  assign als   = {i2.line_start, i1.line_start, i0.line_start};
  assign afs   = {i2.frame_start, i1.frame_start, i0.frame_start};

  task automatic chk(string name, int d, longint act, longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", name, d, $time, act, want);
    end
  endtask

  // Reference: the state is just the number of enabled clock edges since reset.
  // Every output follows from that count by division/modulo arithmetic.
  longint unsigned ecnt [3];

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) ecnt[i] <= 0;
      else if (en[i]) ecnt[i] <= ecnt[i] + 1;
    end
  end

  function automatic exp_t model(int i, longint unsigned e, bit en_i, bit rn);
    cfg_t c;
    exp_t o;
    longint n, ht, vt;
    c  = get_cfg(i);
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    n  = longint'(e / c.k);
    o.x = n % ht;
    o.y = (n / ht) % vt;
    o.tick = rn && en_i && ((e % c.k) == c.k - 1);
    if (n > 0) begin
      o.hs  = (o.x >= c.hv + c.hf && o.x < c.hv + c.hf + c.hs) ? c.hp : ~c.hp;
      o.vs  = (o.y >= c.vv + c.vf && o.y < c.vv + c.vf + c.vs) ? c.vp : ~c.vp;
      o.vid = (o.x < c.hv) && (o.y < c.vv);
    end else begin
      o.hs  = ~c.hp;
      o.vs  = ~c.vp;
      o.vid = 1'b0;
    end
    o.ls = en_i && (e > 0) && ((e % c.k) == 0) && (o.x == 0);
    o.fs = o.ls && (o.y == 0);
    return o;
  endfunction

  int line_ticks = 0;
  int last_line_ticks = -1;

  always @(negedge clk) begin
    exp_t m;
    for (int i = 0; i < 3; i++) begin
      m = model(i, ecnt[i], en[i], reset_n);
      chk("pixel_x", i, longint'(ax[i]), m.x);
      chk("pixel_y", i, longint'(ay[i]), m.y);
      chk("pixel_tick", i, longint'(atick[i]), longint'(m.tick));
      chk("hsync", i, longint'(ahs[i]), longint'(m.hs));
      chk("vsync", i, longint'(avs[i]), longint'(m.vs));
      chk("video_on", i, longint'(avid[i]), longint'(m.vid));
      chk("line_start", i, longint'(als[i]), longint'(m.ls));
      chk("frame_start", i, longint'(afs[i]), longint'(m.fs));
    end
    if (als[0]) begin
      last_line_ticks = line_ticks;
      line_ticks = 0;
    end
    if (atick[0]) line_ticks++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_on) begin
      en[1] = ($urandom_range(0, 7) != 0);
      en[2] = ($urandom_range(0, 7) != 0);
      if (rand0) en[0] = ($urandom_range(0, 7) != 0);
    end
  endtask

  initial begin
    int n;
    int hl;
    int vh;
    bit seen;

    // Reset state
    repeat (3) step();
    chk("rst_x", 0, longint'(ax[0]), 0);
    chk("rst_hsync", 0, longint'(ahs[0]), 1);
    chk("rst_vsync", 1, longint'(avs[1]), 0);
    chk("rst_video", 0, longint'(avid[0]), 0);
    reset_n = 1'b1;
    en = 3'b111;

    // First tick after release, then counters at (1,0) and visible
    step();
    chk("first_tick", 0, longint'(atick[0]), 1);
    chk("first_x", 0, longint'(ax[0]), 0);
    chk("first_vid", 0, longint'(avid[0]), 0);
    step();
    chk("after_tick_x", 0, longint'(ax[0]), 1);
    chk("after_tick_y", 0, longint'(ay[0]), 0);
    chk("after_tick_vid", 0, longint'(avid[0]), 1);
    chk("after_tick_tick", 0, longint'(atick[0]), 0);
    rand_on = 1'b1;

    // Horizontal timing over one full line of dut0
    seen = 1'b0;
    for (int j = 0; j < 4000 && !seen; j++) begin
      if (als[0]) seen = 1'b1;
      else step();
    end
    chk("wait_line_start", 0, longint'(seen), 1);
    hl = 0;
    vh = 0;
    for (int j = 0; j < 1600; j++) begin
      if (!ahs[0]) hl++;
      if (avid[0]) vh++;
      step();
    end
    chk("hsync_low_clks", 0, hl, 192);
    chk("video_on_clks", 0, vh, 1280);
    chk("line_spacing", 0, longint'(als[0]), 1);

    // Pause at pixel_x=700 for 37 clks
    seen = 1'b0;
    for (int j = 0; j < 2000 && !seen; j++) begin
      if (ax[0] == 10'd700) seen = 1'b1;
      else step();
    end
    chk("wait_x700", 0, longint'(seen), 1);
    en[0] = 1'b0;
    for (int j = 0; j < 37; j++) begin
      step();
      chk("pause_x", 0, longint'(ax[0]), 700);
      chk("pause_hsync", 0, longint'(ahs[0]), 0);
      chk("pause_tick", 0, longint'(atick[0]), 0);
      chk("pause_ls", 0, longint'(als[0]), 0);
    end
    en[0] = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 2000 && !seen; j++) begin
      step();
      if (als[0]) seen = 1'b1;
    end
    chk("wait_line_after_pause", 0, longint'(seen), 1);
    @(negedge clk);
    #1;
    chk("ticks_per_paused_line", 0, last_line_ticks, 800);

    // Wrap corner on the small configuration
    rand_on = 1'b0;
    en[1] = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 200 && !seen; j++) begin
      step();
      if (ax[1] == 10'd7 && ay[1] == 10'd5) seen = 1'b1;
    end
    chk("wait_corner", 1, longint'(seen), 1);
    step();
    chk("corner_x", 1, longint'(ax[1]), 0);
    chk("corner_y", 1, longint'(ay[1]), 0);
    chk("corner_ls", 1, longint'(als[1]), 1);
    chk("corner_fs", 1, longint'(afs[1]), 1);
    chk("corner_vid", 1, longint'(avid[1]), 1);
    chk("corner_vsync", 1, longint'(avs[1]), 0);
    n = 0;
    seen = 1'b0;
    for (int j = 0; j < 100 && !seen; j++) begin
      step();
      n++;
      if (afs[1]) seen = 1'b1;
    end
    chk("frame_spacing", 1, n, 48);
    rand_on = 1'b1;

    // Asynchronous reset mid-frame, no clock edge
    @(posedge clk);
    en[0] = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_x", 0, longint'(ax[0]), 0);
    chk("arst_y", 0, longint'(ay[0]), 0);
    chk("arst_hsync", 0, longint'(ahs[0]), 1);
    chk("arst_vsync", 0, longint'(avs[0]), 1);
    chk("arst_vid", 0, longint'(avid[0]), 0);
    chk("arst_tick", 1, longint'(atick[1]), 0);
    chk("arst_ls", 0, longint'(als[0]), 0);
    chk("arst_fs", 0, longint'(afs[0]), 0);
    step();
    step();
    reset_n = 1'b1;

    // Long randomized-enable run on every configuration
    rand0 = 1'b1;
    repeat (6000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
